match_controller: RTL

Sequences a match for the ball-and-paddle game: latches the game mode and bat size at start, runs the serve delay, enables ball motion, awards points from goal and hit events, and ends the match at the winning score. It sits between the ball-physics block (which reports goals and hits) and `video_encoder`, driving `video_encoder`'s `mode`, `bat_size`, `p1_score` and `p2_score` inputs.

---
 rtl/game_pkg.sv | 24 ++
 rtl/match_controller_if.sv | 36 +++
 rtl/frame_timer.sv | 30 +++
 rtl/match_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the ball-and-paddle match sequencer.
package game_pkg;

    localparam logic [1:0] MODE_TENNIS   = 2'b00;
    localparam logic [1:0] MODE_FOOTBALL = 2'b01;
    localparam logic [1:0] MODE_SQUASH   = 2'b10;
    localparam logic [1:0] MODE_PRACTICE = 2'b11;

    localparam logic PLAYER_P1 = 1'b0;
    localparam logic PLAYER_P2 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        OVER
    } ctl_state_t;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/match_controller_if.sv
// Event inputs from ball physics and the control/score bundle to video.
interface match_controller_if;

    logic       frame_tick;
    logic       start;
    logic [1:0] mode_sel;
    logic       bat_sel;
    logic       goal_l;
    logic       goal_r;
    logic       hit_p1;
    logic       hit_p2;

    logic [1:0] mode;
    logic       bat_size;
    logic [4:0] p1_score;
    logic [4:0] p2_score;
    logic       ball_en;
    logic       serve;
    logic       serve_dir;
    logic       game_over;

    modport slave (
        input  frame_tick, start, mode_sel, bat_sel,
        input  goal_l, goal_r, hit_p1, hit_p2,
        output mode, bat_size, p1_score, p2_score,
        output ball_en, serve, serve_dir, game_over
    );

    modport master (
        output frame_tick, start, mode_sel, bat_sel,
        output goal_l, goal_r, hit_p1, hit_p2,
        input  mode, bat_size, p1_score, p2_score,
        input  ball_en, serve, serve_dir, game_over
    );

endinterface

// File: rtl/frame_timer.sv
// Counts frame ticks; done fires on the tick that reaches term_i.
module frame_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       tick_i,
    input  logic [7:0] term_i,
    output logic       done_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (tick_i)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = tick_i && !clr_i && (cnt_q == term_i - 8'd1);

endmodule

// File: rtl/match_controller.sv
// Match sequencer: serve delay, ball enable, scoring and game-over hold.
module match_controller
    import game_pkg::*;
#(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic               clk,
    input  logic               rst,
    match_controller_if.slave  bus
);

    localparam logic [4:0] WIN_T   = 5'(WIN_SCORE);
    localparam logic [7:0] SERVE_T = 8'(SERVE_FRAMES);
    localparam logic [7:0] OVER_T  = 8'(OVER_FRAMES);

    ctl_state_t state_q;
    logic       start_q;
    logic [1:0] mode_q;
    logic       bat_q;
    logic [4:0] p1_q, p2_q;
    logic       ben_q, serve_q, dir_q, over_q;
    logic       hitter_q, winner_q;

    logic       start_edge;
    logic       tmr_clr, tmr_done;
    logic [7:0] tmr_term;
    logic       point_d, winner_d, dir_d, hitter_d;
    logic       inc_p1, inc_p2;
    logic [4:0] win_score;

    assign start_edge = bus.start && !start_q;
    assign tmr_clr    = state_q inside {IDLE, PLAY, POINT};
    assign tmr_term   = (state_q == OVER) ? OVER_T : SERVE_T;
    assign win_score  = (winner_q == PLAYER_P2) ? p2_q : p1_q;

    frame_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tmr_clr),
        .tick_i (bus.frame_tick),
        .term_i (tmr_term),
        .done_o (tmr_done)
    );

    // Scoring decision for the current PLAY cycle; squash uses the
    // hitter held before this cycle's hit pulses.
    always_comb begin
        point_d  = 1'b0;
        winner_d = winner_q;
        dir_d    = dir_q;
        inc_p1   = 1'b0;
        inc_p2   = 1'b0;
        hitter_d = hitter_q;
        if (bus.hit_p2)
            hitter_d = PLAYER_P2;
        else if (bus.hit_p1)
            hitter_d = PLAYER_P1;
        case (mode_q)
            MODE_SQUASH: begin
                if (bus.goal_l) begin
                    point_d  = 1'b1;
                    winner_d = hitter_q;
                    hitter_d = hitter_q;
                    dir_d    = 1'b0;
                    inc_p1   = (hitter_q == PLAYER_P1);
                    inc_p2   = (hitter_q == PLAYER_P2);
                end
            end
            MODE_PRACTICE: begin
                inc_p1   = bus.hit_p1;
                inc_p2   = bus.goal_l;
                point_d  = bus.goal_l;
                winner_d = PLAYER_P2;
                dir_d    = 1'b0;
            end
            default: begin
                if (bus.goal_l) begin
                    point_d  = 1'b1;
                    winner_d = PLAYER_P2;
                    dir_d    = 1'b1;
                    inc_p2   = 1'b1;
                end else if (bus.goal_r) begin
                    point_d  = 1'b1;
                    winner_d = PLAYER_P1;
                    dir_d    = 1'b0;
                    inc_p1   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b1;
            mode_q   <= MODE_TENNIS;
            bat_q    <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
            ben_q    <= 1'b0;
            serve_q  <= 1'b0;
            dir_q    <= 1'b0;
            over_q   <= 1'b0;
            hitter_q <= PLAYER_P1;
            winner_q <= PLAYER_P1;
        end else begin
            start_q <= bus.start;
            serve_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    mode_q <= bus.mode_sel;
                    bat_q  <= bus.bat_sel;
                    if (start_edge) begin
                        p1_q     <= '0;
                        p2_q     <= '0;
                        dir_q    <= 1'b0;
                        hitter_q <= PLAYER_P1;
                        state_q  <= SERVE;
                    end
                end
                SERVE: begin
                    if (start_edge) begin
                        state_q <= IDLE;
                    end else if (tmr_done) begin
                        state_q <= PLAY;
                        serve_q <= 1'b1;
                        ben_q   <= 1'b1;
                    end
                end
                PLAY: begin
                    if (start_edge) begin
                        state_q <= IDLE;
                        ben_q   <= 1'b0;
                    end else begin
                        hitter_q <= hitter_d;
                        dir_q    <= dir_d;
                        if (inc_p1)
                            p1_q <= sat_inc(p1_q);
                        if (inc_p2)
                            p2_q <= sat_inc(p2_q);
                        if (point_d) begin
                            state_q  <= POINT;
                            ben_q    <= 1'b0;
                            winner_q <= winner_d;
                        end
                    end
                end
                POINT: begin
                    if (start_edge) begin
                        state_q <= IDLE;
                    end else if (win_score == WIN_T) begin
                        state_q <= OVER;
                        over_q  <= 1'b1;
                    end else begin
                        state_q <= SERVE;
                    end
                end
                OVER: begin
                    if (tmr_done) begin
                        state_q <= IDLE;
                        over_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mode      = mode_q;
    assign bus.bat_size  = bat_q;
    assign bus.p1_score  = p1_q;
    assign bus.p2_score  = p2_q;
    assign bus.ball_en   = ben_q;
    assign bus.serve     = serve_q;
    assign bus.serve_dir = dir_q;
    assign bus.game_over = over_q;

endmodule
